// File: rtl/busy_requester.sv
// Queues start requests for a downstream busy-timer, launches one run at a time,
// and watches the timer's busy handshake with rise/fall timeouts.
module busy_requester #(
  parameter int MAX_PENDING  = 8,
  parameter int RISE_TIMEOUT = 4,
  parameter int MAX_BUSY     = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_busy,
  input  logic       i_clr_err,
  output logic       o_start,
  output logic       o_full,
  output logic [3:0] o_pending,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [7:0] timer_q, timer_d;
  logic       start_q, done_q, err_q;
  logic       done_d;
  logic       accept;
  logic       launch;

  assign o_full  = (pending_q == 4'(MAX_PENDING));
  assign accept  = i_req && !o_full;
  // A run is only launched when the timer reports idle, so a stale busy never
  // gets mistaken for the response to our own start pulse.
  assign launch  = (state_q == IDLE) && (pending_q != 4'd0) && !i_busy;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) state_d = START;
      end
      START: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_busy) state_d = WAIT_DONE;
        else if (timer_q == 8'(RISE_TIMEOUT - 1)) state_d = ERROR;
      end
      WAIT_DONE: begin
        if (!i_busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_q == 8'(MAX_BUSY - 1)) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        if (i_clr_err) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    case ({accept, launch})
      2'b10:   pending_d = pending_q + 4'd1;
      2'b01:   pending_d = pending_q - 4'd1;
      default: pending_d = pending_q;
    endcase
  end

  // Timer restarts on every state change and saturates rather than wrapping.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = 8'd0;
    end else if (((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) && (timer_q != 8'hFF)) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pending_q <= 4'd0;
      timer_q   <= 8'd0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      start_q   <= (state_d == START);
      done_q    <= done_d;
      err_q     <= (state_d == ERROR);
    end
  end

  assign o_start   = start_q;
  assign o_done    = done_q;
  assign o_err     = err_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_busy_requester.sv
// Directed bench for busy_requester: a per-cycle vector table followed by
// hand-written sequences for saturation, timeouts and asynchronous reset.
module tb_busy_requester;

  typedef struct {
    logic       req;
    logic       busy;
    logic       clr;
    logic       start;
    logic       done;
    logic       err;
    logic [3:0] pend;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       busy = 1'b0;
  logic       clrErr = 1'b0;
  logic       start;
  logic       full;
  logic [3:0] pending;
  logic       done;
  logic       err;

  int   checks = 0;
  int   failures = 0;
  int   startCount = 0;
  int   doneCount = 0;
  int   overlapCount = 0;
  int   startBase;
  int   doneBase;
  bit   seen;
  vec_t vecs[$];

  busy_requester #(
    .MAX_PENDING (8),
    .RISE_TIMEOUT(4),
    .MAX_BUSY    (32)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_busy   (busy),
    .i_clr_err(clrErr),
    .o_start  (start),
    .o_full   (full),
    .o_pending(pending),
    .o_done   (done),
    .o_err    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (start) startCount++;
      if (done) doneCount++;
      if (start && done) overlapCount++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic c);
    req    = r;
    busy   = b;
    clrErr = c;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic r, input logic b, input logic c,
                        input logic s, input logic d, input logic e, input logic [3:0] p);
    vec_t v;
    v.req = r; v.busy = b; v.clr = c;
    v.start = s; v.done = d; v.err = e; v.pend = p;
    vecs.push_back(v);
  endtask

  task automatic doReset;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitStart(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (start) found = 1'b1;
    end
  endtask

  task automatic waitDone(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Columns: req busy clr | start done err pending (o_full low throughout)
    addVec(1,0,0, 0,0,0,4'd1);
    addVec(1,0,0, 1,0,0,4'd1);
    addVec(0,0,0, 0,0,0,4'd1);
    addVec(0,1,0, 0,0,0,4'd1);
    addVec(0,1,0, 0,0,0,4'd1);
    addVec(0,0,0, 0,1,0,4'd1);
    addVec(0,0,0, 1,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,1,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,1,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(1,1,0, 0,0,0,4'd1);
    addVec(0,1,0, 0,0,0,4'd1);
    addVec(0,0,0, 1,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,0,1,4'd0);
    addVec(1,0,0, 0,0,1,4'd1);
    addVec(1,0,0, 0,0,1,4'd2);
    addVec(0,0,1, 0,0,0,4'd2);
    addVec(0,0,0, 1,0,0,4'd1);
    addVec(0,0,0, 0,0,0,4'd1);
    addVec(0,1,0, 0,0,0,4'd1);
    addVec(0,0,0, 0,1,0,4'd1);
    addVec(0,0,0, 1,0,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);
    addVec(0,1,0, 0,0,0,4'd0);
    addVec(0,0,0, 0,1,0,4'd0);
    addVec(0,0,0, 0,0,0,4'd0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_state", {8'd0, start, done, err, full, pending}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].req, vecs[i].busy, vecs[i].clr);
      tick();
      checkOutput($sformatf("vec%0d", i), {8'd0, start, done, err, full, pending},
                  {8'd0, vecs[i].start, vecs[i].done, vecs[i].err, 1'b0, vecs[i].pend});
    end

    // Single run with busy held for 21 cycles after the start pulse.
    doReset();
    startBase = startCount;
    doneBase  = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("single_pend1", {12'd0, pending}, 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitStart(5, seen);
    checkOutput("single_start_seen", {15'd0, seen}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (21) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitDone(3, seen);
    checkOutput("single_done_seen", {15'd0, seen}, 16'd1);
    tick();
    checkOutput("single_starts", 16'(startCount - startBase), 16'd1);
    checkOutput("single_dones", 16'(doneCount - doneBase), 16'd1);
    checkOutput("single_end", {13'd0, err, pending == 4'd0, full}, 16'b010);

    // Ten back-to-back requests while busy: queue saturates at eight.
    doReset();
    startBase = startCount;
    doneBase  = doneCount;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (7) tick();
    checkOutput("sat_pend7", {11'd0, full, pending}, {11'd0, 1'b0, 4'd7});
    repeat (3) tick();
    checkOutput("sat_pend8", {11'd0, full, pending}, {11'd0, 1'b1, 4'd8});
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitStart(6, seen);
      checkOutput($sformatf("sat_start%0d", r), {15'd0, seen}, 16'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitDone(4, seen);
      checkOutput($sformatf("sat_done%0d", r), {15'd0, seen}, 16'd1);
    end
    repeat (4) tick();
    checkOutput("sat_starts", 16'(startCount - startBase), 16'd8);
    checkOutput("sat_dones", 16'(doneCount - doneBase), 16'd8);
    checkOutput("sat_end", {11'd0, full, pending}, 16'd0);

    // Busy stuck high: error exactly after 32 cycles in WAIT_DONE.
    doReset();
    doneBase = doneCount;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitStart(5, seen);
    checkOutput("stuck_start_seen", {15'd0, seen}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (33) tick();
    checkOutput("stuck_err_before", {15'd0, err}, 16'd0);
    tick();
    checkOutput("stuck_err_after", {15'd0, err}, 16'd1);
    repeat (3) tick();
    checkOutput("stuck_no_done", 16'(doneCount - doneBase), 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("stuck_clr", {15'd0, err}, 16'd0);

    // Asynchronous reset mid-cycle while in WAIT_DONE with three queued.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("arst_start", {11'd0, start, pending}, {11'd0, 1'b1, 4'd3});
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    doneBase = doneCount;
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_outputs", {8'd0, start, done, err, full, pending}, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("arst_no_done", 16'(doneCount - doneBase), 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("resume_pend", {12'd0, pending}, 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("resume_start", {11'd0, start, pending}, {11'd0, 1'b1, 4'd0});

    checkOutput("start_done_overlap", 16'(overlapCount), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/busy_requester.md
BUSY_REQUESTER -- requirements
Module: busy_requester

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 8, max queued start requests (1..15).
REQ-002 SHALL have parameter RISE_TIMEOUT, default 4, cycles allowed in WAIT_BUSY for i_busy to assert (1..255).
REQ-003 SHALL have parameter MAX_BUSY, default 32, cycles allowed in WAIT_DONE for i_busy to deassert (1..255).
REQ-004 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  1  request one busy-timer run; accepted when o_full low.
REQ-007 i_busy  input  1  busy indication from the downstream countdown timer.
REQ-008 i_clr_err  input  1  clears error state.
REQ-009 o_start  output  1  registered one-cycle start pulse to the timer's trigger input.
REQ-010 o_full  output  1  combinational, pending == MAX_PENDING.
REQ-011 o_pending  output  4  registered count of accepted, not-yet-started requests.
REQ-012 o_done  output  1  registered one-cycle pulse per completed run.
REQ-013 o_err  output  1  registered, high while in ERROR.

Function
REQ-014 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, ERROR; one state register.
REQ-015 Accept = i_req && !o_full; accept SHALL increment pending at the clock edge.
REQ-016 Request while o_full SHALL be dropped; pending unchanged.
REQ-017 IDLE -> START when pending != 0 && !i_busy; pending SHALL decrement on that edge.
REQ-018 Accept and IDLE->START in the same cycle SHALL leave pending unchanged.
REQ-019 IDLE with i_busy high SHALL hold (no start), regardless of pending.
REQ-020 o_start SHALL be high exactly while state == START (one cycle); START -> WAIT_BUSY unconditionally.
REQ-021 WAIT_BUSY: i_busy high -> WAIT_DONE, timer cleared; else timer increments; timer == RISE_TIMEOUT-1 with i_busy low -> ERROR.
REQ-022 WAIT_DONE: i_busy low -> IDLE with o_done pulsed in the following cycle; timer == MAX_BUSY-1 with i_busy high -> ERROR.
REQ-023 Timer SHALL be 8 bits, cleared on every state change, never wrap within a state.
REQ-024 ERROR: o_err high; new requests still accepted; no starts issued; i_clr_err -> IDLE, pending retained.
REQ-025 Back-to-back runs: earliest next o_start is 2 cycles after o_done-causing edge (IDLE then START).
REQ-026 o_done and o_start SHALL never be high in the same cycle.

Reset
REQ-027 i_rst high SHALL immediately force state IDLE, pending 0, timer 0, o_start 0, o_done 0, o_err 0, independent of i_clk.
REQ-028 Reset mid-run SHALL discard the run in flight and all pending requests; no o_done issued.
REQ-029 Operation SHALL resume on the first rising edge after i_rst deasserts.

Verification
REQ-030 Single req, i_busy high 1 cycle after o_start for 21 cycles -> one o_start, one o_done, o_pending 1->0, o_err 0.
REQ-031 10 reqs on consecutive cycles, busy held -> o_pending saturates at 8, o_full high, reqs 9-10 dropped, exactly 8 o_done after busy releases each run.
REQ-032 o_start with i_busy never asserting -> ERROR after 4 WAIT_BUSY cycles, o_err 1; i_clr_err -> IDLE, retained pending restarts.
REQ-033 i_busy stuck high 32 cycles in WAIT_DONE -> o_err 1, no o_done.
REQ-034 i_rst pulse (mid-cycle, async) during WAIT_DONE with pending 3 -> all outputs 0 and o_pending 0 before next clock edge.
REQ-035 i_req coincident with IDLE->START, pending 1 -> o_pending stays 1, o_start pulses once.
